// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : instruction_fetch                                      |
// | Description : PC, req/ack instruction fetch and one-entry IR with    |
// |               valid/ready handoff and branch redirect/flush.         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] instr,
    output logic [4:0]  opcode,
    output logic [10:0] immediate,
    output logic [15:0] instr_pc
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        redir_pend_q, redir_pend_d;
    logic [15:0] redir_pc_q, redir_pc_d;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_FETCH;
            req_q        <= 1'b0;
            pc_q         <= RESET_PC;
            instr_q      <= 16'h0000;
            instr_pc_q   <= 16'h0000;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        case (state_q)
            S_FETCH: begin
                // req_q low only in the first cycle after reset: nothing outstanding yet
                if (!req_q) begin
                    if (branch_taken) begin
                        pc_d = branch_target;
                    end
                end else if (imem_ack) begin
                    if (branch_taken) begin
                        pc_d         = branch_target;
                        redir_pend_d = 1'b0;
                    end else if (redir_pend_q) begin
                        pc_d         = redir_pc_q;
                        redir_pend_d = 1'b0;
                    end else begin
                        instr_d    = imem_data;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + PC_STEP;
                        state_d    = S_HOLD;
                    end
                end else if (branch_taken) begin
                    redir_pend_d = 1'b1;
                    redir_pc_d   = branch_target;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = S_FETCH;
                end else if (ir_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
        req_d = (state_d == S_FETCH);
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign ir_valid  = (state_q == S_HOLD);
    assign instr     = instr_q;
    assign opcode    = instr_q[15:11];
    assign immediate = instr_q[10:0];
    assign instr_pc  = instr_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_instruction_fetch                                   |
// | Description : Scoreboard bench for the instruction fetch stage.      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_instruction_fetch;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic [10:0] immediate;
    logic [15:0] instr_pc;

    typedef struct {
        logic [15:0] data;
        logic [15:0] pc;
    } sb_t;

    sb_t sb[$];
    int  total = 0;
    int  bad   = 0;

    instruction_fetch #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .instr         (instr),
        .opcode        (opcode),
        .immediate     (immediate),
        .instr_pc      (instr_pc)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Memory driver: answers the outstanding request this cycle; keep=1 means the
    // word is expected to reach the IR, so it goes on the scoreboard.
    task automatic do_ack(input logic [15:0] d, input logic [15:0] at_pc, input bit keep);
        sb_t e;
        imem_ack  = 1'b1;
        imem_data = d;
        if (keep) begin
            e.data = d;
            e.pc   = at_pc;
            sb.push_back(e);
        end
        step();
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
    endtask

    task automatic test_reset();
        #2 Reset = 1'b1;
        step();
        step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ir_valid); end
        total++; if (instr !== 16'h0000) begin bad++; $display("FAIL rst_instr got=%h exp=0000", instr); end
        total++; if (opcode !== 5'd0 || immediate !== 11'd0) begin
            bad++; $display("FAIL rst_fields got=%h/%h exp=0/0", opcode, immediate);
        end
        Reset = 1'b0;
        step();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_rel_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL rst_rel_addr got=%h exp=0000", imem_addr); end
    endtask

    task automatic test_sequential();
        sb_t e;
        logic [15:0] words [2];
        logic [4:0]  ops   [2];
        words[0] = 16'h0B9B; ops[0] = 5'b00001;
        words[1] = 16'hF39B; ops[1] = 5'b11110;
        ir_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            total++; if (imem_addr !== 16'(2 * i)) begin bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imem_addr, 16'(2 * i)); end
            do_ack(words[i], 16'(2 * i), 1'b1);
            total++; if (ir_valid !== 1'b1 || imem_req !== 1'b0) begin
                bad++; $display("FAIL seq_hs%0d got=%b%b exp=10", i, ir_valid, imem_req);
            end
            if (sb.size() == 0) begin
                total++; bad++; $display("FAIL seq_sb_empty got=0 exp=1");
            end else begin
                e = sb.pop_front();
                total++; if (opcode !== ops[i]) begin bad++; $display("FAIL seq_opcode%0d got=%b exp=%b", i, opcode, ops[i]); end
                total++; if (immediate !== 11'h39B) begin bad++; $display("FAIL seq_imm%0d got=%h exp=39b", i, immediate); end
                total++; if (instr !== e.data || instr_pc !== e.pc) begin
                    bad++; $display("FAIL seq_instr%0d got=%h@%h exp=%h@%h", i, instr, instr_pc, e.data, e.pc);
                end
            end
            step();
        end
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin
            bad++; $display("FAIL seq_addr2 got=%b/%h exp=1/0004", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        branch_taken  = 1'b1;
        branch_target = 16'h0200;
        step();
        total++; if (imem_addr !== 16'h0004 || imem_req !== 1'b1) begin
            bad++; $display("FAIL rw_hold1 got=%b/%h exp=1/0004", imem_req, imem_addr);
        end
        branch_target = 16'h0100;
        step();
        branch_taken = 1'b0;
        total++; if (imem_addr !== 16'h0004 || ir_valid !== 1'b0) begin
            bad++; $display("FAIL rw_hold2 got=%b/%h exp=0/0004", ir_valid, imem_addr);
        end
        do_ack(16'h7777, 16'h0004, 1'b0);
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL rw_valid got=%b exp=0", ir_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
            bad++; $display("FAIL rw_addr got=%b/%h exp=1/0100", imem_req, imem_addr);
        end
    endtask

    task automatic test_backpressure();
        sb_t e;
        ir_ready = 1'b0;
        do_ack(16'h1234, 16'h0100, 1'b1);
        for (int i = 0; i < 5; i++) begin
            total++; if (ir_valid !== 1'b1 || imem_req !== 1'b0 || sb.size() == 0 || instr !== sb[0].data) begin
                bad++; $display("FAIL bp_hold%0d got=%b%b/%h exp=10/1234", i, ir_valid, imem_req, instr);
            end
            step();
        end
        ir_ready = 1'b1;
        if (sb.size() == 0) begin
            total++; bad++; $display("FAIL bp_sb_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            total++; if (instr !== e.data || instr_pc !== e.pc || ir_valid !== 1'b1) begin
                bad++; $display("FAIL bp_accept got=%h@%h exp=%h@%h", instr, instr_pc, e.data, e.pc);
            end
        end
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0102 || ir_valid !== 1'b0) begin
            bad++; $display("FAIL bp_resume got=%b/%h exp=1/0102", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_hold();
        sb_t e;
        ir_ready = 1'b1;
        do_ack(16'h5555, 16'h0102, 1'b1);
        total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL rh_valid got=%b exp=1", ir_valid); end
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        if (sb.size() != 0) e = sb.pop_front();
        step();
        branch_taken = 1'b0;
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL rh_flush got=%b exp=0", ir_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
            bad++; $display("FAIL rh_addr got=%b/%h exp=1/0040", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        sb_t e;
        ir_ready      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 16'hFFFE;
        do_ack(16'h9999, 16'h0040, 1'b0);
        branch_taken = 1'b0;
        total++; if (ir_valid !== 1'b0 || imem_addr !== 16'hFFFE) begin
            bad++; $display("FAIL wr_redir got=%b/%h exp=0/fffe", ir_valid, imem_addr);
        end
        do_ack(16'hABCD, 16'hFFFE, 1'b1);
        if (sb.size() == 0) begin
            total++; bad++; $display("FAIL wr_sb_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            total++; if (ir_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin
                bad++; $display("FAIL wr_instr got=%b %h@%h exp=1 %h@%h", ir_valid, instr, instr_pc, e.data, e.pc);
            end
        end
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            bad++; $display("FAIL wr_addr got=%b/%h exp=1/0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        sb_t e;
        logic [15:0] words [3];
        words[0] = 16'h0B9B;
        words[1] = 16'hF39B;
        words[2] = 16'h4ABC;
        ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (imem_req !== 1'b1 || imem_addr !== 16'(2 * i)) begin
                bad++; $display("FAIL b2b_addr%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, 16'(2 * i));
            end
            do_ack(words[i], 16'(2 * i), 1'b1);
            if (sb.size() == 0) begin
                total++; bad++; $display("FAIL b2b_sb_empty got=0 exp=1");
            end else begin
                e = sb.pop_front();
                total++; if (ir_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc
                             || opcode !== e.data[15:11] || immediate !== e.data[10:0]) begin
                    bad++; $display("FAIL b2b_instr%0d got=%b %h@%h exp=1 %h@%h", i, ir_valid, instr, instr_pc, e.data, e.pc);
                end
            end
            step();
        end
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin
            bad++; $display("FAIL b2b_end got=%b/%h exp=1/0006", imem_req, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        #3 Reset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin
            bad++; $display("FAIL ar_hs got=%b%b exp=00", imem_req, ir_valid);
        end
        total++; if (instr !== 16'h0000 || instr_pc !== 16'h0000 || opcode !== 5'd0) begin
            bad++; $display("FAIL ar_instr got=%h@%h exp=0000@0000", instr, instr_pc);
        end
        step();
        Reset = 1'b0;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            bad++; $display("FAIL ar_release got=%b/%h exp=1/0000", imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_wait();
        test_backpressure();
        test_redirect_hold();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
